// File: rtl/seq_tx_hex_if.sv
// Link between the sequencer send path, seq_tx_hex and the UART TX byte port.
// The master modport belongs to whoever issues requests and takes the bytes.
interface seq_tx_hex_if #(
  parameter int ALU_WIDTH = 16
);
  logic [ALU_WIDTH-1:0] i_data;
  logic                 i_valid;
  logic                 o_ready;
  logic [7:0]           o_byte;
  logic                 o_byte_valid;
  logic                 i_byte_ready;
  logic                 o_done;

  modport master (
    output i_data, i_valid, i_byte_ready,
    input  o_ready, o_byte, o_byte_valid, o_done
  );

  modport slave (
    input  i_data, i_valid, i_byte_ready,
    output o_ready, o_byte, o_byte_valid, o_done
  );
endinterface

// File: rtl/seq_tx_hex.sv
// Serialises one ALU result as uppercase ASCII hex (MSB nibble first),
// optionally followed by CR LF, over a byte-wide valid/ready link.
module seq_tx_hex #(
  parameter int ALU_WIDTH = 16,
  parameter bit EOL_EN    = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  seq_tx_hex_if.slave  bus
);
  localparam int NIB   = ALU_WIDTH / 4;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, DIGIT, CR, LF} state_t;

  state_t               state_q, state_d;
  logic [ALU_WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [7:0]           byte_p1, byte_d;
  logic                 vld_p1, vld_d;
  logic                 ready_p1, ready_d;
  logic                 done_p1, done_d;
  logic                 xfer;
  logic                 msg_end;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

  function automatic logic [3:0] nib_at(input logic [ALU_WIDTH-1:0] d,
                                        input logic [CNT_W-1:0]     idx);
    logic [ALU_WIDTH-1:0] sh;
    sh = d >> {idx, 2'b00};
    return sh[3:0];
  endfunction

  assign xfer = vld_p1 & bus.i_byte_ready;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    byte_d  = byte_p1;
    vld_d   = vld_p1;
    ready_d = ready_p1;
    done_d  = 1'b0;
    msg_end = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.i_valid && ready_p1) begin
          data_d  = bus.i_data;
          cnt_d   = CNT_W'(NIB - 1);
          byte_d  = hex_ascii(nib_at(bus.i_data, CNT_W'(NIB - 1)));
          vld_d   = 1'b1;
          ready_d = 1'b0;
          state_d = DIGIT;
        end
      end
      DIGIT: begin
        if (xfer) begin
          if (cnt_q != '0) begin
            cnt_d  = cnt_q - CNT_W'(1);
            byte_d = hex_ascii(nib_at(data_q, cnt_q - CNT_W'(1)));
          end else if (EOL_EN) begin
            state_d = CR;
            byte_d  = 8'h0D;
          end else begin
            msg_end = 1'b1;
          end
        end
      end
      CR: begin
        if (xfer) begin
          state_d = LF;
          byte_d  = 8'h0A;
        end
      end
      LF: begin
        if (xfer) msg_end = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Last byte accepted: drop valid, reopen for requests, pulse done.
    if (msg_end) begin
      state_d = IDLE;
      byte_d  = 8'h00;
      vld_d   = 1'b0;
      ready_d = 1'b1;
      done_d  = 1'b1;
    end
  end

  // ---- registered output stage ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      data_q   <= '0;
      cnt_q    <= '0;
      byte_p1  <= 8'h00;
      vld_p1   <= 1'b0;
      ready_p1 <= 1'b1;
      done_p1  <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      byte_p1  <= byte_d;
      vld_p1   <= vld_d;
      ready_p1 <= ready_d;
      done_p1  <= done_d;
    end
  end

  assign bus.o_byte       = byte_p1;
  assign bus.o_byte_valid = vld_p1;
  assign bus.o_ready      = ready_p1;
  assign bus.o_done       = done_p1;
endmodule
